rgbw_spi_slave: RTL and testbench

RGBW_SPI_SLAVE -- requirements
Module: rgbw_spi_slave

---
 rtl/rgbw_spi_slave.sv | 151 +++++++++++++++
 tb/tb_rgbw_spi_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgbw_spi_slave.sv
// SPI mode-0 receive slave: synchronizes sclk/cs_n/mosi into clk, assembles bytes MSB first
// and presents each as buffRx_spi with a rdy level. Optional macro SPI_MISO_ECHO_EN echoes the previous byte on miso.
module rgbw_spi_slave #(
  parameter int unsigned RDY_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] buffRx_spi,
  output logic       rdy,
  output logic       frame_err,
  output logic       ovr,
  output logic       dbg_state
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [3:0] HOLD_INIT = 4'(RDY_HOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] sclk_s_q;
  logic [1:0] cs_s_q;
  logic [1:0] mosi_s_q;
  logic [1:0] valid_q;
  logic       armed_q, armed_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       load_q;
  logic [7:0] buff_q, buff_d;
  logic       rdy_q, rdy_d;
  logic [3:0] hold_q, hold_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       sclk_rise;

  assign sclk_rise = sclk_s_q[1] & ~sclk_s_q[2];

  // rdy is a plain level with no back-pressure: buffRx_spi is valid whenever rdy is high
  // and stays put until the next byte completes; the consumer must sample within the hold.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    // Only accept a frame after a genuine cs_n high has been sampled since reset.
    armed_d = armed_q | (valid_q[1] & cs_s_q[1]);
    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (armed_q && !cs_s_q[1]) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_s_q[1]) begin
          state_d = IDLE;
          ferr_d  = (cnt_q != 3'd0);
          cnt_d   = 3'd0;
        end else if (sclk_rise) begin
          shift_d = {shift_q[6:0], mosi_s_q[1]};
          cnt_d   = cnt_q + 3'd1;
          done_d  = (cnt_q == 3'd7);
        end
      end
    endcase
  end

  always_comb begin
    buff_d = buff_q;
    rdy_d  = rdy_q;
    hold_d = hold_q;
    ovr_d  = done_q & rdy_q;
    if (done_q) buff_d = shift_q;
    if (load_q) begin
      rdy_d  = 1'b1;
      hold_d = HOLD_INIT;
    end else if (rdy_q && !done_q) begin
      if (hold_q == 4'd0) rdy_d = 1'b0;
      else                hold_d = hold_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_s_q <= 3'b000;
      cs_s_q   <= 2'b11;
      mosi_s_q <= 2'b00;
      valid_q  <= 2'b00;
      armed_q  <= 1'b0;
      state_q  <= IDLE;
      shift_q  <= 8'h00;
      cnt_q    <= 3'd0;
      done_q   <= 1'b0;
      load_q   <= 1'b0;
      buff_q   <= 8'h00;
      rdy_q    <= 1'b0;
      hold_q   <= 4'd0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sclk_s_q <= {sclk_s_q[1:0], sclk};
      cs_s_q   <= {cs_s_q[0], cs_n};
      mosi_s_q <= {mosi_s_q[0], mosi};
      valid_q  <= {valid_q[0], 1'b1};
      armed_q  <= armed_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      load_q   <= done_q;
      buff_q   <= buff_d;
      rdy_q    <= rdy_d;
      hold_q   <= hold_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef SPI_MISO_ECHO_EN
  logic [7:0] tx_q, tx_d;
  logic       sclk_fall;

  assign sclk_fall = ~sclk_s_q[1] & sclk_s_q[2];

  // The fall that ends a byte reloads with the byte just completed, so each byte echoes its predecessor.
  always_comb begin
    tx_d = tx_q;
    if (state_q == IDLE && state_d == SHIFT)      tx_d = buff_q;
    else if (state_q == SHIFT && sclk_fall)       tx_d = (cnt_q == 3'd0) ? buff_q : {tx_q[6:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_q <= 8'h00;
    else        tx_q <= tx_d;
  end

  assign miso = (state_q == SHIFT) & tx_q[7];
`else
  assign miso = 1'b0;
`endif

  assign buffRx_spi = buff_q;
  assign rdy        = rdy_q;
  assign frame_err  = ferr_q;
  assign ovr        = ovr_q;
  assign dbg_state  = (state_q == SHIFT);

endmodule

// File: tb/tb_rgbw_spi_slave.sv
// Bench for rgbw_spi_slave: directed and random SPI frames against a byte-level scoreboard.
module tb_rgbw_spi_slave;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, rdy, frame_err, ovr, dbg_state;
  logic [7:0] buff;
  logic       miso15, rdy15, ferr15, ovr15, dbg15;
  logic [7:0] buff15;

  always #5 clk = ~clk;

  rgbw_spi_slave u_dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .buffRx_spi(buff), .rdy(rdy), .frame_err(frame_err), .ovr(ovr),
    .dbg_state(dbg_state)
  );

  rgbw_spi_slave #(.RDY_HOLD(15)) u_dut15 (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso15), .buffRx_spi(buff15), .rdy(rdy15), .frame_err(ferr15), .ovr(ovr15),
    .dbg_state(dbg15)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_byte = 8'h00;
  int         exp_ferr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard/monitor for the RDY_HOLD=4 instance
  bit         rdy_prev, ferr_prev, ovr_prev;
  int         hi_cnt, low_cnt = 100;
  logic [7:0] buff_at_rise;
  int         rdy_rises = 0, ferr_cnt = 0, ovr_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      rdy_prev = 1'b0; ferr_prev = 1'b0; ovr_prev = 1'b0;
      hi_cnt = 0; low_cnt = 100;
    end else begin
      if (rdy && !rdy_prev) begin
        rdy_rises++;
        check("rdy_gap", (low_cnt >= 2) ? 1 : 0, 1);
        check("rdy_pending", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) check("rx_byte", 32'(buff), 32'(exp_q.pop_front()));
`ifndef SPI_MISO_ECHO_EN
        check("miso_const", 32'(miso), 0);
`endif
        buff_at_rise = buff;
        hi_cnt = 1;
      end else if (rdy) begin
        hi_cnt++;
        check("buff_stable", 32'(buff), 32'(buff_at_rise));
      end else if (rdy_prev) begin
        check("rdy_width", hi_cnt, 4);
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      if (frame_err) begin
        if (!ferr_prev) ferr_cnt++;
        check("ferr_width", 32'(ferr_prev), 0);
      end
      if (ovr) begin
        if (!ovr_prev) ovr_cnt++;
        check("ovr_width", 32'(ovr_prev), 0);
      end
      rdy_prev = rdy; ferr_prev = frame_err; ovr_prev = ovr;
    end
  end

  bit r15_prev, o15_prev;
  int r15_rises = 0, o15_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      r15_prev = 1'b0; o15_prev = 1'b0;
    end else begin
      if (rdy15 && !r15_prev) r15_rises++;
      if (ovr15 && !o15_prev) o15_cnt++;
      r15_prev = rdy15; o15_prev = ovr15;
    end
  end

  // Driver: called on a negedge with sclk low; sends the top nbits of b MSB first.
  task automatic spi_xfer(input logic [7:0] b, input int nbits, input int half, input bit push,
                          input bit chk_lat, output logic [7:0] cap);
    cap = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      repeat (half) @(negedge clk);
      cap[i] = miso;
      sclk = 1'b1;
      if (i == 0 && push) exp_q.push_back(b);
      if (i == 0 && chk_lat) begin
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 check("rdy_lat_3", 32'(rdy), 0);
        @(posedge clk);
        #1 check("rdy_lat_4", 32'(rdy), 1);
        @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int half, input bit chk_lat);
    logic [7:0] cap;
    spi_xfer(b, 8, half, 1'b1, chk_lat, cap);
    // Echo is only defined at legal sclk rates.
    if (half >= 3) begin
`ifdef SPI_MISO_ECHO_EN
      check("miso_echo", 32'(cap), 32'(last_byte));
`else
      check("miso_zero", 32'(cap), 0);
`endif
    end
    last_byte = b;
  endtask

  task automatic cs_lo();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_hi();
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] tbl [8];
    logic [7:0] cap;
    int         snap, snap15, osnap15, nb, half;

    tbl = '{8'h55, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h7F, 8'h10, 8'h02};

    repeat (3) @(negedge clk);
    check("rst_buff", 32'(buff), 0);
    check("rst_rdy", 32'(rdy), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_ovr", 32'(ovr), 0);
    check("rst_miso", 32'(miso), 0);
    check("rst_state", 32'(dbg_state), 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte with exact rdy latency
    snap = rdy_rises;
    cs_lo();
    send_byte(8'h55, 4, 1'b1);
    cs_hi();
    repeat (4) @(negedge clk);
    check("b55_rises", rdy_rises - snap, 1);
    check("b55_buff", 32'(buff), 'h55);
    check("b55_ferr", ferr_cnt, 0);
    check("b55_ovr", ovr_cnt, 0);

    // Partial byte then cs_n release
    snap = rdy_rises;
    cs_lo();
    spi_xfer(8'hA0, 5, 4, 1'b0, 1'b0, cap);
    cs_hi();
    exp_ferr++;
    repeat (10) @(negedge clk);
    check("part_ferr", ferr_cnt, exp_ferr);
    check("part_rises", rdy_rises - snap, 0);
    check("part_buff", 32'(buff), 'h55);

    // Eight-byte frame
    snap = rdy_rises;
    cs_lo();
    for (int k = 0; k < 8; k++) send_byte(tbl[k], 4, 1'b0);
    cs_hi();
    repeat (10) @(negedge clk);
    check("frame8_rises", rdy_rises - snap, 8);
    check("frame8_buff", 32'(buff), 'h02);

    // Random frames at legal rates
    for (int f = 0; f < 6; f++) begin
      nb = int'($urandom_range(1, 4));
      half = int'($urandom_range(4, 6));
      cs_lo();
      for (int k = 0; k < nb; k++) begin
        send_byte(8'($urandom), half, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      cs_hi();
      repeat (10) @(negedge clk);
      check("rand_buff", 32'(buff), 32'(last_byte));
      check("rand_drained", exp_q.size(), 0);
    end
    check("rand_ferr", ferr_cnt, exp_ferr);

    // A legal-rate byte needs >=48 clk, longer than any hold, so overrun is provoked with a clk/2 burst.
    repeat (30) @(negedge clk);
    snap15 = r15_rises;
    osnap15 = o15_cnt;
    cs_lo();
    send_byte(8'hA5, 1, 1'b0);
    send_byte(8'h3C, 1, 1'b0);
    cs_hi();
    repeat (30) @(negedge clk);
    check("ovr15_pulses", o15_cnt - osnap15, 1);
    check("ovr15_rdy_cont", r15_rises - snap15, 1);
    check("ovr15_buff", 32'(buff15), 'h3C);
    check("ovr4_none", ovr_cnt, 0);

    // Reset in the middle of a byte
    cs_lo();
    spi_xfer(8'hC3, 4, 4, 1'b0, 1'b0, cap);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_buff", 32'(buff), 0);
    check("arst_rdy", 32'(rdy), 0);
    check("arst_state", 32'(dbg_state), 0);
    exp_q.delete();
    last_byte = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    snap = rdy_rises;
    spi_xfer(8'hAA, 8, 4, 1'b0, 1'b0, cap);
    repeat (10) @(negedge clk);
    check("unarmed_rises", rdy_rises - snap, 0);
    check("unarmed_state", 32'(dbg_state), 0);
    cs_hi();
    cs_lo();
    send_byte(8'hC3, 4, 1'b0);
    cs_hi();
    repeat (10) @(negedge clk);
    check("rearm_rises", rdy_rises - snap, 1);
    check("rearm_buff", 32'(buff), 'hC3);

    // Echo pair: the second byte's miso carries the first
    cs_lo();
    send_byte(8'h5A, 4, 1'b0);
    send_byte(8'h00, 4, 1'b0);
    cs_hi();
    check("miso_cs_high", 32'(miso), 0);

    repeat (20) @(negedge clk);
    check("final_drained", exp_q.size(), 0);
    check("final_ferr", ferr_cnt, exp_ferr);
    check("final_ovr", ovr_cnt, 0);
    check("final_buff", 32'(buff), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
